mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Sequencer between the MEM pipeline stage and an SRAM-like data bus with a split address/data handshake.
- Accepts one load or store from the MEM stage and checks its alignment.
- Generates the byte strobes and replicated store data, drives the bus handshake, and stalls the pipeline until the access completes.
- Returns sign- or zero-extended load data for writeback.

Parameters:
TIMEOUT_CYC, 255, max cycles spent in ADDR+DATA before abort with bus_err; 8-bit counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  MEM stage presents a memory op; held stable while stall_out=1
req_wr  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word; 3 treated as word
req_unsigned  in  1  zero-extend load (LBU/LHU)
req_addr  in  32  byte address
req_wdata  in  32  store source register value
flush  in  1  kill current op (exception/redirect)
stall_out  out  1  freeze pipeline
rdata_out  out  32  extended load data
rdata_valid  out  1  1-cycle pulse, rdata_out valid
adel  out  1  load address misaligned
ades  out  1  store address misaligned
bad_addr  out  32  faulting address
bus_err  out  1  1-cycle pulse on timeout
d_req  out  1  bus request
d_wr  out  1  bus write
d_size  out  2  latched size
d_addr  out  32  latched address
d_wdata  out  32  replicated store data
d_wstrb  out  4  byte strobes
d_addr_ok  in  1  address accepted
d_data_ok  in  1  read data valid / write done
d_rdata  in  32  bus read data

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE; all registered outputs and latches 0.
  - d_req deasserts on the cycle after rst is sampled, even mid-transfer.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0.
  - adel/ades/bad_addr are combinational, only in IDLE with req_valid=1 and flush=0.
  - A misaligned op raises no stall and issues no bus request.
- Strobes:
  - byte: 4'b0001<<addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
  - d_wstrb=0 for loads.
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- FSM states IDLE, ADDR, DATA, DONE.
  - IDLE: on req_valid & aligned & !flush, latch wr/size/unsigned/addr/wdata, clear the timeout counter, go to ADDR.
  - ADDR: d_req=1.
    - d_addr_ok & d_data_ok → DONE and capture data.
    - d_addr_ok alone → DATA.
    - flush before d_addr_ok → IDLE; no transaction.
  - DATA: d_req=0. On d_data_ok, capture data and go to DONE. Flush here is recorded (kill flag) and does not abort; the bus must drain.
  - DONE: rdata_valid=1 only for loads with kill=0. stall_out=0. Always → IDLE; the op presented this cycle is not re-accepted.
- stall_out = (IDLE & req_valid & aligned & !flush) | ADDR | DATA.
- Latency: best case is accept (IDLE) → ADDR with both oks → DONE. That is 2 stall cycles and 3 cycles of occupancy; back-to-back ops have a 1-cycle IDLE gap.
- Load extraction uses the latched addr[1:0], is registered on d_data_ok, and is held until the next accept.
  - byte: lane addr[1:0], extended from bit 7.
  - half: lane addr[1], extended from bit 15.
  - Extension is sign unless req_unsigned=1, which zero-extends.
- Timeout:
  - The counter increments in ADDR/DATA.
  - When it reaches TIMEOUT_CYC: pulse bus_err, go to IDLE, release stall, no rdata_valid.
  - Bus state after a timeout is the bus owner's responsibility.

Test Plan:
- LW addr 0x100, d_addr_ok and d_data_ok both asserted on the first ADDR cycle, d_rdata=0xDEADBEEF → stall_out high 2 cycles, rdata_out=0xDEADBEEF, rdata_valid pulse in DONE.
- LB addr 0x203 with d_rdata=0x80FF1234 → rdata_out=0xFFFFFF80; LBU same → 0x00000080; LH addr 0x202 → 0xFFFF80FF.
- SB addr 0x301 with req_wdata=0x000000AB → d_wstrb=0010, d_wdata=0xABABABAB; SH addr 0x302 → d_wstrb=1100; no rdata_valid.
- LW addr 0x102 → adel=1, bad_addr=0x102, d_req never asserts, stall_out=0; SH addr 0x101 → ades=1.
- Flush in ADDR with d_addr_ok low → IDLE next cycle, no bus transaction. Flush in DATA → stall_out held until d_data_ok, no rdata_valid.
- d_addr_ok never asserted → bus_err pulses after 255 cycles, stall_out drops. Assert rst mid-DATA → d_req=0 and all outputs 0 the next cycle.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences one MEM-stage load/store onto a split address/data
// SRAM-style bus. It checks alignment, builds strobes and replicated write data,
// stalls the pipeline while the access is in flight, and returns extended load data.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for an aligned, unflushed request
// ADDR  | d_req high, waiting for d_addr_ok (d_data_ok may arrive with it)
// DATA  | address accepted, waiting for d_data_ok; flush only marks kill
// DONE  | access complete, stall released, load data valid unless killed
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_addr,
    output logic        bus_err,
    output logic        d_req,
    output logic        d_wr,
    output logic [1:0]  d_size,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_addr_ok,
    input  logic        d_data_ok,
    input  logic [31:0] d_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // The abort fires in the busy cycle whose increment would make the
    // counter reach TIMEOUT_CYC, so at most TIMEOUT_CYC busy cycles are spent.
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  r_state;
    logic        r_wr;
    logic        r_unsigned;
    logic        r_kill;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_cnt;

    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_present;
    logic        w_accept;
    logic        w_busy;
    logic        w_timeout;
    logic        w_data_cap;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_is_half  = (req_size == 2'd1);
    assign w_is_word  = req_size[1];
    assign w_misalign = (w_is_half & req_addr[0]) | (w_is_word & (|req_addr[1:0]));
    assign w_present  = (r_state == ST_IDLE) & req_valid & ~flush;
    assign w_accept   = w_present & ~w_misalign;
    assign w_busy     = (r_state == ST_ADDR) | (r_state == ST_DATA);
    assign w_timeout  = w_busy & (r_cnt == LP_TO_LAST);
    assign w_data_cap = ((r_state == ST_ADDR) & d_addr_ok & d_data_ok) |
                        ((r_state == ST_DATA) & d_data_ok);

    // Strobes and lane-replicated store data for the request being accepted
    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                w_strb  = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
        if (!req_wr) begin
            w_strb = 4'b0000;
        end
    end

    // Lane select and sign/zero extension of returning load data
    always_comb begin
        w_byte = d_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? d_rdata[31:16] : d_rdata[15:0];
        case (r_size)
            2'd0:    w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = d_rdata;
        endcase
    end

    // Sequencer, request latches, kill flag, timeout counter and load capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr       <= 1'b0;
            r_unsigned <= 1'b0;
            r_kill     <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_cnt      <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wr       <= req_wr;
                        r_unsigned <= req_unsigned;
                        r_size     <= req_size;
                        r_addr     <= req_addr;
                        r_wdata    <= w_wdata;
                        r_wstrb    <= w_strb;
                        r_kill     <= 1'b0;
                        r_cnt      <= 8'd0;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (d_addr_ok) begin
                        // Address already taken by the bus: the access must
                        // complete, a flush only suppresses the result.
                        if (flush) begin
                            r_kill <= 1'b1;
                        end
                        r_state <= d_data_ok ? ST_DONE : ST_DATA;
                    end else if (flush) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (d_data_ok) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_data_cap && !r_wr && !w_timeout) begin
                r_rdata <= w_load;
            end
        end
    end

    assign stall_out   = w_accept | (w_busy & ~w_timeout);
    assign rdata_valid = (r_state == ST_DONE) & ~r_wr & ~r_kill;
    assign rdata_out   = r_rdata;
    assign bus_err     = w_timeout;
    assign adel        = w_present & w_misalign & ~req_wr;
    assign ades        = w_present & w_misalign & req_wr;
    assign bad_addr    = (adel | ades) ? req_addr : 32'd0;
    assign d_req       = (r_state == ST_ADDR);
    assign d_wr        = r_wr;
    assign d_size      = r_size;
    assign d_addr      = r_addr;
    assign d_wdata     = r_wdata;
    assign d_wstrb     = r_wstrb;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: directed loads/stores with a scoreboard queue of
// expected bus handshakes, load results and timeout pulses, checked by a monitor.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        adel;
    logic        ades;
    logic [31:0] bad_addr;
    logic        bus_err;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .stall_out(stall_out),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid), .adel(adel),
        .ades(ades), .bad_addr(bad_addr), .bus_err(bus_err), .d_req(d_req),
        .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata)
    );

    localparam int K_HS = 0;
    localparam int K_LD = 1;
    localparam int K_BE = 2;

    typedef struct {
        int          kind;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int          st;
    int          nr;
    logic        o_adel;
    logic        o_ades;
    logic [31:0] o_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic push(input int k, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.kind = k; e.wr = wr; e.sz = sz; e.a = a; e.d = d; e.s = s;
        q.push_back(e);
    endtask

    task automatic take(input int k, input string nm);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: event seen with nothing expected (kind %0d)", nm, k);
            return;
        end
        e = q.pop_front();
        chk({nm, "_kind"}, k, e.kind);
        if (k == K_HS) begin
            chk({nm, "_wr"}, {31'd0, d_wr}, {31'd0, e.wr});
            chk({nm, "_size"}, {30'd0, d_size}, {30'd0, e.sz});
            chk({nm, "_addr"}, d_addr, e.a);
            chk({nm, "_strb"}, {28'd0, d_wstrb}, {28'd0, e.s});
            if (e.wr) chk({nm, "_wdata"}, d_wdata, e.d);
        end else if (k == K_LD) begin
            chk({nm, "_data"}, rdata_out, e.d);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a handshake, load or error
    always @(negedge clk) begin
        #2;
        if (d_req && d_addr_ok) take(K_HS, "bus_hs");
        if (rdata_valid)        take(K_LD, "rdata");
        if (bus_err)            take(K_BE, "bus_err");
    end

    // One request with a scripted bus: a_lat ADDR cycles before d_addr_ok,
    // d_lat DATA cycles (0 = data with address), flush on cycle fl_cyc (-1 none)
    task automatic do_op(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int a_lat, input int d_lat,
                         input int fl_cyc, output int stalls, output int nreq,
                         output logic oa, output logic os, output logic [31:0] ob);
        int phase;
        int na;
        int nd;
        bit done;
        phase = 0; na = 0; nd = 0; done = 0;
        stalls = 0; nreq = 0; oa = 1'b0; os = 1'b0; ob = 32'd0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; d_rdata = rd;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            d_addr_ok = 1'b0;
            d_data_ok = 1'b0;
            if (fl_cyc >= 0 && cyc == fl_cyc) flush = 1'b1;
            if (fl_cyc >= 0 && cyc == fl_cyc + 1) begin
                flush = 1'b0;
                req_valid = 1'b0;
            end
            if (phase == 0 && d_req) begin
                nreq++;
                if (na >= a_lat) begin
                    d_addr_ok = 1'b1;
                    if (d_lat == 0) begin
                        d_data_ok = 1'b1;
                        phase = 2;
                    end else begin
                        phase = 1;
                    end
                end
                na++;
            end else if (phase == 1) begin
                if (nd >= d_lat - 1) begin
                    d_data_ok = 1'b1;
                    phase = 2;
                end
                nd++;
            end
            #1;
            if (cyc == 0) begin
                oa = adel; os = ades; ob = bad_addr;
            end
            if (stall_out) stalls++;
            else done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL op_wait: stall_out never dropped within 400 cycles");
        end
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0; d_addr_ok = 1'b0; d_data_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; flush = 1'b0;
        d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_dreq", {31'd0, d_req}, 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_daddr", d_addr, 32'd0);
        chk("rst_buserr", {31'd0, bus_err}, 32'd0);
        rst = 1'b0;

        // Word load, both oks on first ADDR cycle
        push(K_HS, 1'b0, 2'd2, 32'h100, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd2, 32'h100, 32'hDEADBEEF, 4'b0000);
        do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        chk("lw_stalls", st, 32'd2);

        // Byte/half loads with sign and zero extension
        push(K_HS, 1'b0, 2'd0, 32'h203, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd0, 32'h203, 32'hFFFFFF80, 4'b0000);
        do_op(1'b0, 2'd0, 1'b0, 32'h203, 32'd0, 32'h80FF1234, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        push(K_HS, 1'b0, 2'd0, 32'h203, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd0, 32'h203, 32'h00000080, 4'b0000);
        do_op(1'b0, 2'd0, 1'b1, 32'h203, 32'd0, 32'h80FF1234, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        push(K_HS, 1'b0, 2'd1, 32'h202, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd1, 32'h202, 32'hFFFF80FF, 4'b0000);
        do_op(1'b0, 2'd1, 1'b0, 32'h202, 32'd0, 32'h80FF1234, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        push(K_HS, 1'b0, 2'd1, 32'h202, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd1, 32'h202, 32'h000080FF, 4'b0000);
        do_op(1'b0, 2'd1, 1'b1, 32'h202, 32'd0, 32'h80FF1234, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        push(K_HS, 1'b0, 2'd0, 32'h200, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd0, 32'h200, 32'h00000034, 4'b0000);
        do_op(1'b0, 2'd0, 1'b0, 32'h200, 32'd0, 32'h80FF1234, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);

        // Slow bus: 2 wait cycles on address, data in 3rd DATA cycle
        push(K_HS, 1'b0, 2'd2, 32'h108, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd2, 32'h108, 32'h0BADF00D, 4'b0000);
        do_op(1'b0, 2'd2, 1'b0, 32'h108, 32'd0, 32'h0BADF00D, 2, 3, -1, st, nr, o_adel, o_ades, o_bad);
        chk("lw_slow_stalls", st, 32'd7);

        // Stores: strobes and replicated data, no load result
        push(K_HS, 1'b1, 2'd0, 32'h301, 32'hABABABAB, 4'b0010);
        do_op(1'b1, 2'd0, 1'b0, 32'h301, 32'h000000AB, 32'd0, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        chk("sb_stalls", st, 32'd2);
        push(K_HS, 1'b1, 2'd1, 32'h302, 32'hCDEFCDEF, 4'b1100);
        do_op(1'b1, 2'd1, 1'b0, 32'h302, 32'h1234CDEF, 32'd0, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        push(K_HS, 1'b1, 2'd2, 32'h304, 32'h11223344, 4'b1111);
        do_op(1'b1, 2'd2, 1'b0, 32'h304, 32'h11223344, 32'd0, 1, 1, -1, st, nr, o_adel, o_ades, o_bad);
        chk("sw_slow_stalls", st, 32'd4);

        // Misaligned load and store
        do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'd0, 32'd0, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        chk("lw_mis_adel", {31'd0, o_adel}, 32'd1);
        chk("lw_mis_ades", {31'd0, o_ades}, 32'd0);
        chk("lw_mis_bad", o_bad, 32'h102);
        chk("lw_mis_dreq", nr, 32'd0);
        chk("lw_mis_stalls", st, 32'd0);
        do_op(1'b1, 2'd1, 1'b0, 32'h101, 32'd0, 32'd0, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        chk("sh_mis_ades", {31'd0, o_ades}, 32'd1);
        chk("sh_mis_adel", {31'd0, o_adel}, 32'd0);
        chk("sh_mis_bad", o_bad, 32'h101);
        chk("sh_mis_dreq", nr, 32'd0);

        // Flush in ADDR before address accepted: no transaction at all
        do_op(1'b0, 2'd2, 1'b0, 32'h500, 32'd0, 32'h55555555, 1000, 0, 1, st, nr, o_adel, o_ades, o_bad);
        chk("flush_addr_stalls", st, 32'd2);
        chk("flush_addr_dreq", nr, 32'd1);

        // Flush in DATA: bus drains, stall held, load result suppressed
        push(K_HS, 1'b0, 2'd2, 32'h504, 32'd0, 4'b0000);
        do_op(1'b0, 2'd2, 1'b0, 32'h504, 32'd0, 32'h66666666, 0, 3, 2, st, nr, o_adel, o_ades, o_bad);
        chk("flush_data_stalls", st, 32'd5);

        // Address never accepted: abort after 255 busy cycles
        push(K_BE, 1'b0, 2'd0, 32'd0, 32'd0, 4'b0000);
        do_op(1'b0, 2'd2, 1'b0, 32'h600, 32'd0, 32'd0, 1000, 0, -1, st, nr, o_adel, o_ades, o_bad);
        chk("timeout_stalls", st, 32'd255);
        chk("timeout_dreq", nr, 32'd255);

        // Reset while in DATA
        push(K_HS, 1'b0, 2'd2, 32'h700, 32'd0, 4'b0000);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h700; d_rdata = 32'd0;
        @(negedge clk);
        d_addr_ok = 1'b1;
        @(negedge clk);
        d_addr_ok = 1'b0;
        #1;
        chk("rstd_pre_stall", {31'd0, stall_out}, 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rstd_dreq", {31'd0, d_req}, 32'd0);
        chk("rstd_stall", {31'd0, stall_out}, 32'd0);
        chk("rstd_daddr", d_addr, 32'd0);
        chk("rstd_dsize", {30'd0, d_size}, 32'd0);
        chk("rstd_rdata", rdata_out, 32'd0);
        chk("rstd_rvalid", {31'd0, rdata_valid}, 32'd0);
        rst = 1'b0;

        // Reset while in ADDR drops d_req on the next cycle
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h704;
        @(negedge clk);
        #1;
        chk("rsta_pre_dreq", {31'd0, d_req}, 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rsta_dreq", {31'd0, d_req}, 32'd0);
        rst = 1'b0;

        // Recovery after reset
        push(K_HS, 1'b0, 2'd2, 32'h800, 32'd0, 4'b0000);
        push(K_LD, 1'b0, 2'd2, 32'h800, 32'h12345678, 4'b0000);
        do_op(1'b0, 2'd2, 1'b0, 32'h800, 32'd0, 32'h12345678, 0, 0, -1, st, nr, o_adel, o_ades, o_bad);
        chk("recover_stalls", st, 32'd2);

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
